// File: rtl/dsp_result_collector.sv
// dsp_result_collector: credit-gated capture of DSP pipeline results into an in-order FIFO
module dsp_result_collector #(
    parameter int N       = 48,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              p_in,
    output logic                      out_valid,
    output logic [N-1:0]              out_data,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = LATENCY > 0 ? LATENCY : 1;

    logic [LW-1:0] vld;
    logic          accept;
    logic          wr;
    logic          pop;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [7:0]    outstanding;
    logic [N-1:0]  mem [DEPTH];

    assign accept    = in_valid & in_ready & ce;
    assign pop       = out_valid & out_ready;
    assign out_valid = count != '0;
    assign out_data  = out_valid ? mem[rptr] : '0;

    generate
        if (LATENCY == 0) begin : g_comb
            assign vld = '0;
            assign wr  = accept;
        end else begin : g_pipe
            // Valid tokens ride alongside the DSP pipeline, advancing only on ce
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    vld <= '0;
                else if (ce)
                    vld <= (vld << 1) | LW'(accept);
            end
            assign wr = ce & vld[LW-1];
        end
    endgenerate

    // Credits: every in-flight token already owns a FIFO slot, so writes never meet a full FIFO
    always_comb begin
        outstanding = 8'(count);
        for (int i = 0; i < LW; i++)
            outstanding = outstanding + 8'(vld[i]);
        in_ready = outstanding < 8'(DEPTH);
    end

    // FIFO pointers and occupancy; simultaneous write and pop leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + CW'(wr) - CW'(pop);
        end
    end

    // Result storage; contents are qualified by count so they need no reset
    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= p_in;
    end
endmodule

// File: doc/dsp_result_collector.md
DSP_RESULT_COLLECTOR -- requirements
Module: dsp_result_collector

Interface
REQ-001 Parameter N, default 48, width of the DSP result word.
REQ-002 Parameter LATENCY, default 2, DSP pipeline depth in ce-qualified cycles, legal range 0..4.
REQ-003 Parameter DEPTH, default 4, result FIFO entries, power of two, 2..16.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ce  input  1  pipeline advance enable, shared with the DSP slice.
REQ-007 in_valid  input  1  operand issued to the DSP this cycle.
REQ-008 in_ready  output  1  collector can accept one more issue.
REQ-009 p_in  input  N  DSP P output.
REQ-010 out_valid  output  1  FIFO head holds a result.
REQ-011 out_data  output  N  FIFO head result.
REQ-012 out_ready  input  1  downstream consumes head when out_valid is high.
REQ-013 count  output  log2(DEPTH)+1  number of results stored in the FIFO.

Function
REQ-014 Issue accepted iff in_valid & in_ready & ce; in_valid with ce=0 or in_ready=0 is ignored.
REQ-015 Accepted issues enter a LATENCY-stage valid shift register that advances only when ce=1; stage contents hold when ce=0.
REQ-016 When the last stage's valid emerges on a ce=1 cycle, p_in is written to the FIFO tail that edge; with LATENCY=0 the accepted issue itself writes p_in that edge.
REQ-017 Outstanding = in-flight valids + count; in_ready = (outstanding < DEPTH), combinational from registered state only.
REQ-018 Credit rule guarantees no write ever meets a full FIFO; results are never dropped.
REQ-019 Pop occurs iff out_valid & out_ready, independent of ce.
REQ-020 Simultaneous write and pop: both take effect, count unchanged, order preserved.
REQ-021 Write into an empty FIFO: out_valid rises the following cycle (registered head, one-cycle fall-through latency).
REQ-022 out_data stable while out_valid=1 and out_ready=0.
REQ-023 Read/write pointers wrap modulo DEPTH; count saturation never occurs under REQ-017.
REQ-024 Results emerge in issue order; p_in values at non-valid emerge cycles are ignored.
REQ-025 Pop updates in_ready on the next cycle (registered count), not combinationally.

Reset
REQ-026 rst=1 asynchronously clears valid shift register, pointers and count; out_valid=0, count=0, out_data=0, in_ready=1.
REQ-027 Reset mid-operation discards all in-flight and stored results; no stale result emerges after release.
REQ-028 First accepted issue is honoured on the first rising edge with rst=0.

Verification
REQ-029 LATENCY=2, ce=1, out_ready=1, issue one op, p_in=0x0000_0000_1234 two cycles later -> out_valid high in cycle 3 with out_data=0x1234, count returns to 0.
REQ-030 DEPTH=4, out_ready=0, continuous in_valid -> exactly 4 issues accepted, in_ready low thereafter, count=4, no overwrite.
REQ-031 Full FIFO, out_ready pulsed one cycle -> one pop, in_ready high next cycle, exactly one new issue accepted.
REQ-032 ce toggled 1,0,1,0 with one op in flight, LATENCY=2 -> result captured only on the second ce=1 edge after issue.
REQ-033 Steady stream with out_ready=1, simultaneous push/pop for 20 cycles, values 1..20 -> outputs 1..20 in order, count constant.
REQ-034 rst asserted between clock edges with 3 results stored and 2 in flight -> outputs cleared immediately, nothing emerges after release.
